evm_ballot_controller: RTL and testbench
========================================

Name: evm_ballot_controller

Overview:
- Sequences one ballot at a time for the 4-party vote counter bank.
- Takes a raw push button and the voter party switches. Enforces officer arming, one-hot selection, a timeout and a total-vote cap.
- Issues exactly one single-cycle vote_strobe with a one-hot party code per accepted ballot. The counters increment only on that strobe.

Parameters:
- DEBOUNCE_CYCLES, 4: cycles the synchronized button must stay stable before a level change is accepted (min 2).
- TIMEOUT_CYCLES, 1000: cycles allowed in ARMED before the ballot is abandoned (min 1).
- MAX_TOTAL, 127: cap on total accepted ballots (max 127, fits 7 bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- voting_en  in  1  global enable; low aborts any ballot in progress.
- arm  in  1  officer release; single-cycle or level, sampled in IDLE.
- close_poll  in  1  ends the poll; sticky until reset.
- voter_switch  in  4  party select; must be one-hot at press.
- Push_Button  in  1  raw asynchronous voter button.
- vote_strobe  out  1  one-cycle pulse; counters increment on it.
- vote_party  out  4  one-hot party; valid while vote_strobe=1, 0 otherwise.
- ballot_ready  out  1  high in ARMED.
- err_invalid  out  1  one-cycle pulse: press with non-one-hot select.
- err_timeout  out  1  one-cycle pulse: ARMED timed out.
- poll_full  out  1  high when total_cast == MAX_TOTAL.
- poll_closed  out  1  high in CLOSED.
- total_cast  out  7  accepted-ballot count.

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; debouncer output 0; synchronizer flops 0.
- Button path: 2-flop synchronizer, then debounce counter. The counter reloads whenever the synced value differs from the debounced value. Once it has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced value updates.
- press = 1-cycle pulse on the debounced 0->1 edge.
- Press latency: DEBOUNCE_CYCLES+2 cycles from raw rise to press.
- Glitches shorter than DEBOUNCE_CYCLES produce no press.
- FSM transitions, priority as listed (reset > close_poll > the rest):
  - Any state except CAST, close_poll=1 -> CLOSED next cycle. If in ARMED, the ballot is dropped silently (no error pulse).
  - IDLE: arm && voting_en && !poll_full -> ARMED; timer cleared. Otherwise stay in IDLE.
  - ARMED, voting_en=0 -> IDLE, no error pulse.
  - ARMED, press && voter_switch one-hot (exactly one bit set) -> CAST; party latched into vote_party register.
  - ARMED, press && not one-hot (including 0000) -> err_invalid for 1 cycle; stay ARMED; timer reset to 0.
  - ARMED, timer == TIMEOUT_CYCLES-1 with no press -> IDLE; err_timeout for 1 cycle.
  - ARMED, otherwise: timer increments.
  - If press and timeout coincide, press wins.
  - CAST: vote_strobe=1 with latched vote_party for exactly 1 cycle; total_cast increments (never wraps); -> DONE. close_poll seen in CAST is honoured in DONE on the next cycle.
  - DONE: waits until debounced button = 0, then -> IDLE. A held button therefore cannot cast a second ballot.
  - CLOSED: absorbing; only reset exits. arm and press are ignored; no strobes.
- voter_switch is sampled only on the press cycle. Later switch changes do not affect vote_party.
- poll_full: combinational compare. arm is ignored while it is set.
- Reset mid-CAST: vote_strobe drops immediately (async); the ballot is not counted; total_cast = 0.
- err pulses and vote_strobe are registered outputs; they never overlap.

Test Plan:
- Arm, voter_switch=0010, clean press held 10 cycles (DEBOUNCE_CYCLES=4) -> ballot_ready=1, then one vote_strobe with vote_party=0010 exactly 6 cycles after the raw rise; total_cast=1; return to IDLE only after release.
- Arm, voter_switch=0110, press -> err_invalid pulse; no strobe; still ARMED. Then switch=1000, press -> strobe with vote_party=1000.
- Arm, no press for 1000 cycles -> err_timeout at cycle 1000; IDLE; total_cast unchanged. A 2-cycle glitch on Push_Button produces no press.
- Preload 127 ballots -> poll_full=1; a further arm stays in IDLE; total_cast holds at 127.
- close_poll asserted while in CAST -> strobe still issued, then CLOSED. Subsequent arm and press yield no strobes; poll_closed=1 until reset.
- Drop voting_en while ARMED -> IDLE with no error pulse. Assert reset mid-DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/evm_ballot_controller_if.sv
// ---------------------------------------------------------------------------
// evm_ballot_controller_if
//   Groups the ballot controller's voter/officer inputs and its ballot/status
//   outputs into one bundle. The clock and reset stay outside it as plain
//   ports on the controller.
//
//   Inputs to the controller (driven through the master modport):
//     voting_en     global enable; low aborts a ballot in progress
//     arm           officer release, sampled in IDLE
//     close_poll    ends the poll (absorbing until reset)
//     voter_switch  4-bit party select, must be one-hot at press
//     Push_Button   raw asynchronous voter button
//   Outputs from the controller (driven through the slave modport):
//     vote_strobe   one-cycle pulse per accepted ballot
//     vote_party    one-hot party, non-zero only while vote_strobe is high
//     ballot_ready  high while a ballot is armed
//     err_invalid   one-cycle pulse on a press with a non-one-hot select
//     err_timeout   one-cycle pulse when an armed ballot times out
//     poll_full     total_cast has reached the cap
//     poll_closed   poll has been closed
//     total_cast    accepted-ballot count
// ---------------------------------------------------------------------------
interface evm_ballot_controller_if;
  logic       voting_en;
  logic       arm;
  logic       close_poll;
  logic [3:0] voter_switch;
  logic       Push_Button;

  logic       vote_strobe;
  logic [3:0] vote_party;
  logic       ballot_ready;
  logic       err_invalid;
  logic       err_timeout;
  logic       poll_full;
  logic       poll_closed;
  logic [6:0] total_cast;

  modport master (
    output voting_en, arm, close_poll, voter_switch, Push_Button,
    input  vote_strobe, vote_party, ballot_ready, err_invalid, err_timeout,
           poll_full, poll_closed, total_cast
  );

  modport slave (
    input  voting_en, arm, close_poll, voter_switch, Push_Button,
    output vote_strobe, vote_party, ballot_ready, err_invalid, err_timeout,
           poll_full, poll_closed, total_cast
  );
endinterface

// File: rtl/evm_ballot_controller.sv
// ---------------------------------------------------------------------------
// evm_ballot_controller
//   Sequences one ballot at a time for a 4-party vote counter bank. The raw
//   voter button is synchronized and debounced; an officer must arm each
//   ballot; the party select must be one-hot at the press; an armed ballot
//   times out; the total number of accepted ballots is capped. Each accepted
//   ballot produces exactly one single-cycle vote_strobe with a one-hot
//   vote_party.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset, clears all state
//     bus    evm_ballot_controller_if.slave (see the interface file)
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles the synced button must differ before the
//                      debounced level follows it (>= 2)
//     TIMEOUT_CYCLES   cycles allowed in ARMED before abandoning (>= 1)
//     MAX_TOTAL        cap on accepted ballots (<= 127)
// ---------------------------------------------------------------------------
module evm_ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_TOTAL       = 127
) (
  input logic                    clk,
  input logic                    reset,
  evm_ballot_controller_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_CAST   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CLOSED = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Button path: 2-flop synchronizer followed by a debounce counter.
  // -------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            deb_flip;
  logic            press;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    deb_flip = 1'b0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        deb_d    = sync2_q;
        deb_flip = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // The press pulse is asserted in the cycle whose edge raises the debounced
  // level, so the FSM acts on the press at the same edge the level changes.
  // That makes a raw rise reach CAST DEBOUNCE_CYCLES+2 edges later.
  assign press = deb_flip & sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= bus.Push_Button;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Ballot FSM.
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic [6:0]      total_q, total_d;
  logic            strobe_q, strobe_d;
  logic [3:0]      party_q, party_d;
  logic            err_inv_q, err_inv_d;
  logic            err_to_q, err_to_d;
  // Remembers a close request that arrived during CAST so DONE can act on it.
  logic            close_pend_q, close_pend_d;

  logic            poll_full;
  logic            sel_onehot;

  assign poll_full  = (total_q == 7'(MAX_TOTAL));
  assign sel_onehot = (bus.voter_switch != 4'b0000) &&
                      ((bus.voter_switch & (bus.voter_switch - 4'd1)) == 4'b0000);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    total_d      = total_q;
    strobe_d     = 1'b0;
    party_d      = 4'b0000;
    err_inv_d    = 1'b0;
    err_to_d     = 1'b0;
    close_pend_d = close_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.close_poll) begin
          state_d = ST_CLOSED;
        end else if (bus.arm && bus.voting_en && !poll_full) begin
          state_d = ST_ARMED;
          timer_d = '0;
        end
      end

      ST_ARMED: begin
        if (bus.close_poll) begin
          state_d = ST_CLOSED;
        end else if (!bus.voting_en) begin
          state_d = ST_IDLE;
        end else if (press) begin
          // A press outranks a timeout falling on the same cycle.
          if (sel_onehot) begin
            state_d  = ST_CAST;
            strobe_d = 1'b1;
            party_d  = bus.voter_switch;
          end else begin
            err_inv_d = 1'b1;
            timer_d   = '0;
          end
        end else if (timer_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_CAST: begin
        // The strobe is high throughout this state; the count advances at
        // the edge that ends it, matching the external counters.
        if (bus.close_poll) begin
          close_pend_d = 1'b1;
        end
        if (total_q != 7'(MAX_TOTAL)) begin
          total_d = total_q + 7'd1;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (bus.close_poll || close_pend_q) begin
          state_d = ST_CLOSED;
        end else if (!deb_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_CLOSED: begin
        state_d = ST_CLOSED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      total_q      <= 7'd0;
      strobe_q     <= 1'b0;
      party_q      <= 4'b0000;
      err_inv_q    <= 1'b0;
      err_to_q     <= 1'b0;
      close_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      total_q      <= total_d;
      strobe_q     <= strobe_d;
      party_q      <= party_d;
      err_inv_q    <= err_inv_d;
      err_to_q     <= err_to_d;
      close_pend_q <= close_pend_d;
    end
  end

  assign bus.vote_strobe  = strobe_q;
  assign bus.vote_party   = party_q;
  assign bus.err_invalid  = err_inv_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.ballot_ready = (state_q == ST_ARMED);
  assign bus.poll_closed  = (state_q == ST_CLOSED);
  assign bus.poll_full    = poll_full;
  assign bus.total_cast   = total_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
module tb_evm_ballot_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  evm_ballot_controller_if bif ();

  evm_ballot_controller #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (1000),
    .MAX_TOTAL      (127)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_STROBE  = 0;
  localparam int K_INVALID = 1;
  localparam int K_TIMEOUT = 2;

  typedef struct {
    int         kind;
    logic [3:0] party;
    int         at;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input int kind, input logic [3:0] party, input int at);
    exp_t e;
    e.kind  = kind;
    e.party = party;
    e.at    = at;
    sbq.push_back(e);
  endtask

  task automatic do_arm();
    bif.arm = 1'b1;
    tick(1);
    bif.arm = 1'b0;
  endtask

  // Raw press; kind < 0 means no DUT event is expected for it.
  task automatic press(input logic [3:0] sw, input int kind, input int hold, input int settle);
    bif.voter_switch = sw;
    if (kind >= 0) expect_event(kind, sw, cyc + 6);
    bif.Push_Button = 1'b1;
    tick(hold);
    bif.Push_Button = 1'b0;
    tick(settle);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, int'(bif.vote_strobe), 0);
    check({tag, "_party"},  int'(bif.vote_party), 0);
    check({tag, "_ready"},  int'(bif.ballot_ready), 0);
    check({tag, "_errinv"}, int'(bif.err_invalid), 0);
    check({tag, "_errto"},  int'(bif.err_timeout), 0);
    check({tag, "_full"},   int'(bif.poll_full), 0);
    check({tag, "_closed"}, int'(bif.poll_closed), 0);
    check({tag, "_total"},  int'(bif.total_cast), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    int nev;
    int kind;
    exp_t e;
    nev = int'(bif.vote_strobe) + int'(bif.err_invalid) + int'(bif.err_timeout);
    check("pulse_overlap", (nev > 1) ? 1 : 0, 0);
    if (!bif.vote_strobe) check("party_idle_zero", int'(bif.vote_party), 0);
    if (nev != 0) begin
      kind = bif.vote_strobe ? K_STROBE : (bif.err_invalid ? K_INVALID : K_TIMEOUT);
      if (sbq.size() == 0) begin
        check("unexpected_event_kind", kind, -1);
      end else begin
        e = sbq.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.at);
        if (kind == K_STROBE) check("vote_party", int'(bif.vote_party), int'(e.party));
      end
    end
  end

  initial begin
    int k;
    int karm;
    logic [3:0] sw;

    reset            = 1'b1;
    bif.voting_en    = 1'b0;
    bif.arm          = 1'b0;
    bif.close_poll   = 1'b0;
    bif.voter_switch = 4'b0000;
    bif.Push_Button  = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    bif.voting_en = 1'b1;
    tick(2);

    // Clean press held 10 cycles, select 0010.
    do_arm();
    check("armed_ready", int'(bif.ballot_ready), 1);
    bif.voter_switch = 4'b0010;
    k = cyc;
    expect_event(K_STROBE, 4'b0010, k + 6);
    bif.Push_Button = 1'b1;
    tick(8);
    check("done_ready_low", int'(bif.ballot_ready), 0);
    check("total_after_1", int'(bif.total_cast), 1);
    bif.voter_switch = 4'b0100;
    do_arm();
    check("held_button_blocks_arm", int'(bif.ballot_ready), 0);
    tick(1);
    bif.Push_Button = 1'b0;
    tick(10);

    // Invalid select, then a valid one in the same ballot.
    do_arm();
    check("armed_ready_2", int'(bif.ballot_ready), 1);
    press(4'b0110, K_INVALID, 6, 10);
    check("still_armed_after_invalid", int'(bif.ballot_ready), 1);
    check("total_after_invalid", int'(bif.total_cast), 1);
    press(4'b0000, K_INVALID, 6, 10);
    check("still_armed_after_zero", int'(bif.ballot_ready), 1);
    press(4'b1000, K_STROBE, 6, 10);
    check("total_after_2", int'(bif.total_cast), 2);
    check("idle_after_2", int'(bif.ballot_ready), 0);

    // Timeout, with a 2-cycle glitch that must not count as a press.
    karm = cyc;
    expect_event(K_TIMEOUT, 4'b0000, karm + 1001);
    do_arm();
    tick(5);
    bif.voter_switch = 4'b0001;
    bif.Push_Button = 1'b1;
    tick(2);
    bif.Push_Button = 1'b0;
    tick(karm + 1000 - cyc);
    check("ready_before_timeout", int'(bif.ballot_ready), 1);
    tick(1);
    check("ready_after_timeout", int'(bif.ballot_ready), 0);
    check("total_after_timeout", int'(bif.total_cast), 2);
    tick(3);

    // Dropping voting_en abandons the ballot silently.
    do_arm();
    tick(3);
    bif.voting_en = 1'b0;
    tick(2);
    check("ready_after_disable", int'(bif.ballot_ready), 0);
    do_arm();
    check("arm_ignored_disabled", int'(bif.ballot_ready), 0);
    bif.voting_en = 1'b1;
    tick(2);

    // Reset while in DONE clears everything asynchronously.
    do_arm();
    bif.voter_switch = 4'b0001;
    expect_event(K_STROBE, 4'b0001, cyc + 6);
    bif.Push_Button = 1'b1;
    tick(8);
    check("total_before_reset", int'(bif.total_cast), 3);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bif.Push_Button = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Fill the poll to the cap.
    for (int i = 0; i < 127; i++) begin
      sw = 4'b0001 << (i % 4);
      do_arm();
      press(sw, K_STROBE, 8, 8);
    end
    check("total_at_cap", int'(bif.total_cast), 127);
    check("poll_full_at_cap", int'(bif.poll_full), 1);
    do_arm();
    check("arm_ignored_full", int'(bif.ballot_ready), 0);
    press(4'b0001, -1, 8, 8);
    check("total_holds_cap", int'(bif.total_cast), 127);

    // close_poll during CAST: the strobe still happens, then CLOSED.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    check("total_after_rereset", int'(bif.total_cast), 0);
    do_arm();
    bif.voter_switch = 4'b0100;
    k = cyc;
    expect_event(K_STROBE, 4'b0100, k + 6);
    bif.Push_Button = 1'b1;
    tick(6);
    bif.close_poll = 1'b1;
    tick(1);
    bif.close_poll = 1'b0;
    tick(1);
    check("closed_after_cast", int'(bif.poll_closed), 1);
    check("total_after_close_cast", int'(bif.total_cast), 1);
    bif.Push_Button = 1'b0;
    tick(8);
    do_arm();
    check("arm_ignored_closed", int'(bif.ballot_ready), 0);
    press(4'b0010, -1, 8, 8);
    check("still_closed", int'(bif.poll_closed), 1);
    check("total_frozen_closed", int'(bif.total_cast), 1);

    tick(5);
    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
